// File: rtl/l2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l2_pkg
//  Description : Shared types and constants for the L2 physical-memory line
//                adaptor. Holds the adaptor state enum, the beat-counter
//                width and the line/burst/offset geometry.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package l2_pkg;

    localparam int C_ADDR_W     = 32;   // physical address width
    localparam int C_S_LINE     = 256;  // cache line width in bits
    localparam int C_S_BURST    = 64;   // memory burst beat width in bits
    localparam int C_OFFSET_W   = 5;    // byte-offset bits inside one line
    localparam int C_BEAT_CNT_W = 2;    // counter width for four beats

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ       = 3'd1,
        READ_DONE  = 3'd2,
        WRITE      = 3'd3,
        WRITE_DONE = 3'd4
    } state_e;

endpackage : l2_pkg
`default_nettype wire

// File: rtl/l2_line_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : l2_line_adaptor
//  Description : Responder on the L2 pmem side. Turns a 256-bit line read or
//                write into a four-beat 64-bit burst toward main memory and
//                returns a single-cycle pmem_resp to the L2.
//  Ports       : clk, rst            - clock, async active-high reset
//                pmem_read/write     - L2 line request, held until pmem_resp
//                pmem_address/wdata  - line address / write line (IDLE only)
//                pmem_rdata          - assembled read line (held until the
//                                      next read completes)
//                pmem_resp           - one-cycle completion to L2
//                mem_read/write      - burst request toward memory
//                mem_address         - line-aligned latched address
//                mem_wdata/rdata     - current write / read beat
//                mem_resp            - one strobe per accepted beat
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_line_adaptor
    import l2_pkg::*;
#(
    parameter int S_LINE    = C_S_LINE,
    parameter int S_BURST   = C_S_BURST,
    parameter int NUM_BEATS = S_LINE / S_BURST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pmem_read,
    input  logic                pmem_write,
    input  logic [C_ADDR_W-1:0] pmem_address,
    input  logic [S_LINE-1:0]   pmem_wdata,
    output logic [S_LINE-1:0]   pmem_rdata,
    output logic                pmem_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic [C_ADDR_W-1:0] mem_address,
    output logic [S_BURST-1:0]  mem_wdata,
    input  logic [S_BURST-1:0]  mem_rdata,
    input  logic                mem_resp
);

    localparam logic [C_BEAT_CNT_W-1:0] C_LAST_BEAT = C_BEAT_CNT_W'(NUM_BEATS - 1);

    state_e                  state_q, state_d;
    logic [C_BEAT_CNT_W-1:0] cnt_q,   cnt_d;
    logic [C_ADDR_W-1:0]     addr_q,  addr_d;
    logic [S_LINE-1:0]       wline_q, wline_d;   // latched write line
    logic [S_LINE-1:0]       rbuf_q,  rbuf_d;    // read assembly buffer
    logic [S_LINE-1:0]       rline_q, rline_d;   // completed read line
    logic [S_LINE-1:0]       line_asm;           // rbuf with current beat merged

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rbuf_q  <= rbuf_d;
            rline_q <= rline_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wline_d   = wline_q;
        rbuf_d    = rbuf_q;
        rline_d   = rline_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        pmem_resp = 1'b0;

        line_asm = rbuf_q;
        line_asm[cnt_q*S_BURST +: S_BURST] = mem_rdata;

        case (state_q)
            IDLE: begin
                // Write has priority; a simultaneous read must be re-presented.
                if (pmem_write) begin
                    addr_d  = {pmem_address[C_ADDR_W-1:C_OFFSET_W], {C_OFFSET_W{1'b0}}};
                    wline_d = pmem_wdata;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (pmem_read) begin
                    addr_d  = {pmem_address[C_ADDR_W-1:C_OFFSET_W], {C_OFFSET_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    rbuf_d = line_asm;
                    cnt_d  = cnt_q + 1'b1;
                    // The visible line only changes once the whole line is in,
                    // so pmem_rdata stays stable across later transactions.
                    if (cnt_q == C_LAST_BEAT) begin
                        rline_d = line_asm;
                        state_d = READ_DONE;
                    end
                end
            end
            READ_DONE: begin
                pmem_resp = 1'b1;
                state_d   = IDLE;
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_wdata = wline_q[cnt_q*S_BURST +: S_BURST];
                if (mem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST_BEAT) begin
                        state_d = WRITE_DONE;
                    end
                end
            end
            WRITE_DONE: begin
                pmem_resp = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_address = addr_q;
    assign pmem_rdata  = rline_q;

endmodule : l2_line_adaptor
`default_nettype wire

// File: tb/tb_l2_line_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_line_adaptor
//  Description : Self-checking bench for l2_line_adaptor. Expected read lines
//                and write beats are queued when stimulus is applied and
//                popped when the adaptor produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_line_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [31:0]  pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic         mem_resp = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [255:0] rd_q[$];     // expected completed read lines
    logic [63:0]  wd_q[$];     // expected write beats, in order
    logic [255:0] last_line;   // most recent completed read line

    l2_line_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pmem_resp, mem_read, mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: resp/rd/wr=%b want 000", {pmem_resp, mem_read, mem_write});
        end
        checks++;
        if (mem_address !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h want 0", mem_address);
        end
        checks++;
        if (mem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_wdata: got %h want 0", mem_wdata);
        end
        checks++;
        if (pmem_rdata !== 256'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", pmem_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({pmem_resp, mem_read, mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: resp/rd/wr=%b want 000", {pmem_resp, mem_read, mem_write});
        end
    endtask

    task automatic test_read_back_to_back();
        logic [255:0] line;
        logic [255:0] exp;
        int cyc;
        line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        @(negedge clk);
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_1234;
        rd_q.push_back(line);
        cyc = 1;
        @(negedge clk);
        cyc++;
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rd_req: mem_read=%b mem_write=%b want 1 0", mem_read, mem_write);
        end
        checks++;
        if (mem_address !== 32'h0000_1220) begin
            errors++;
            $display("FAIL rd_addr: got %h want 00001220", mem_address);
        end
        pmem_address = 32'hDEAD_BEEF;   // must not affect the running transaction
        for (int k = 0; k < 4; k++) begin
            mem_resp  = 1'b1;
            mem_rdata = line[64*k +: 64];
            @(negedge clk);
            cyc++;
        end
        mem_resp = 1'b0;
        while (pmem_resp !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 6) begin
            errors++;
            $display("FAIL rd_latency: pmem_resp in cycle %0d want 6", cyc);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_address !== 32'h0000_1220) begin
            errors++;
            $display("FAIL rd_done_outs: mem_read=%b addr=%h want 0 00001220", mem_read, mem_address);
        end
        exp = (rd_q.size() > 0) ? rd_q.pop_front() : 256'h0;
        checks++;
        if (pmem_rdata !== exp) begin
            errors++;
            $display("FAIL rd_line: got %h want %h", pmem_rdata, exp);
        end
        last_line = exp;
        pmem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_resp !== 1'b0 || pmem_rdata !== last_line) begin
            errors++;
            $display("FAIL rd_one_cycle: resp=%b rdata=%h want 0 %h", pmem_resp, pmem_rdata, last_line);
        end
    endtask

    task automatic test_write_with_gaps();
        logic [255:0] wd;
        logic [63:0]  exp;
        for (int i = 0; i < 32; i++) wd[8*i +: 8] = 8'(i);
        @(negedge clk);
        pmem_write   = 1'b1;
        pmem_address = 32'h8000_0040;
        pmem_wdata   = wd;
        for (int k = 0; k < 4; k++) wd_q.push_back(wd[64*k +: 64]);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h8000_0040) begin
            errors++;
            $display("FAIL wr_req: wr=%b rd=%b addr=%h want 1 0 80000040", mem_write, mem_read, mem_address);
        end
        pmem_wdata = '1;   // must not affect the latched line
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                for (int g = 0; g < 2; g++) begin
                    exp = (wd_q.size() > 0) ? wd_q[0] : 64'h0;
                    checks++;
                    if (mem_wdata !== exp || mem_write !== 1'b1) begin
                        errors++;
                        $display("FAIL wr_gap_hold: beat %0d wdata=%h wr=%b want %h 1", k, mem_wdata, mem_write, exp);
                    end
                    @(negedge clk);
                end
            end
            exp = (wd_q.size() > 0) ? wd_q.pop_front() : 64'h0;
            checks++;
            if (mem_wdata !== exp) begin
                errors++;
                $display("FAIL wr_beat: beat %0d got %h want %h", k, mem_wdata, exp);
            end
            mem_resp = 1'b1;
            @(negedge clk);
            mem_resp = 1'b0;
        end
        checks++;
        if (pmem_resp !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: resp=%b wr=%b want 1 0", pmem_resp, mem_write);
        end
        checks++;
        if (pmem_rdata !== last_line) begin
            errors++;
            $display("FAIL wr_keeps_rdata: got %h want %h", pmem_rdata, last_line);
        end
        pmem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL wr_one_cycle: resp=%b want 0", pmem_resp);
        end
    endtask

    task automatic test_simultaneous();
        logic [255:0] wd;
        logic [63:0]  exp;
        for (int i = 0; i < 8; i++) wd[32*i +: 32] = $urandom;
        @(negedge clk);
        pmem_read    = 1'b1;
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0117;
        pmem_wdata   = wd;
        for (int k = 0; k < 4; k++) wd_q.push_back(wd[64*k +: 64]);
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h0000_0100) begin
            errors++;
            $display("FAIL both_prio: wr=%b rd=%b addr=%h want 1 0 00000100", mem_write, mem_read, mem_address);
        end
        for (int k = 0; k < 4; k++) begin
            exp = (wd_q.size() > 0) ? wd_q.pop_front() : 64'h0;
            checks++;
            if (mem_wdata !== exp) begin
                errors++;
                $display("FAIL both_beat: beat %0d got %h want %h", k, mem_wdata, exp);
            end
            mem_resp = 1'b1;
            @(negedge clk);
        end
        mem_resp = 1'b0;
        checks++;
        if (pmem_resp !== 1'b1) begin
            errors++;
            $display("FAIL both_done: resp=%b want 1", pmem_resp);
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        checks++;
        if ({pmem_resp, mem_read, mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL both_no_read: resp/rd/wr=%b want 000", {pmem_resp, mem_read, mem_write});
        end
    endtask

    task automatic test_stray_resp();
        @(negedge clk);
        mem_resp  = 1'b1;
        mem_rdata = {$urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({pmem_resp, mem_read, mem_write} !== 3'b000 || mem_address !== 32'h0000_0100
                || pmem_rdata !== last_line) begin
                errors++;
                $display("FAIL stray_resp: resp/rd/wr=%b addr=%h rdata=%h want 000 00000100 %h",
                         {pmem_resp, mem_read, mem_write}, mem_address, pmem_rdata, last_line);
            end
        end
        mem_resp = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        logic [255:0] old_line;
        logic [255:0] line;
        logic [255:0] exp;
        int resp_seen;
        int cyc;
        old_line = {{8{8'hAA}}, {8{8'hBB}}, {8{8'hCC}}, {8{8'hDD}}};
        @(negedge clk);
        pmem_read    = 1'b1;
        pmem_address = 32'h2000_00A0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            mem_resp  = 1'b1;
            mem_rdata = old_line[64*k +: 64];
            @(negedge clk);
        end
        mem_resp  = 1'b0;
        pmem_read = 1'b0;
        rst       = 1'b1;
        #1;
        checks++;
        if ({pmem_resp, mem_read, mem_write} !== 3'b000 || mem_address !== 32'h0
            || pmem_rdata !== 256'h0 || mem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid_outs: resp/rd/wr=%b addr=%h rdata=%h want 000 0 0",
                     {pmem_resp, mem_read, mem_write}, mem_address, pmem_rdata);
        end
        resp_seen = 0;
        @(negedge clk);
        if (pmem_resp !== 1'b0) resp_seen++;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (pmem_resp !== 1'b0) resp_seen++;
        end
        checks++;
        if (resp_seen != 0) begin
            errors++;
            $display("FAIL rst_mid_no_resp: saw %0d resp cycles want 0", resp_seen);
        end
        for (int k = 0; k < 4; k++) line[64*k +: 64] = {$urandom, $urandom};
        pmem_read    = 1'b1;
        pmem_address = 32'h3000_001F;
        rd_q.push_back(line);
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h3000_0000) begin
            errors++;
            $display("FAIL fresh_req: rd=%b addr=%h want 1 30000000", mem_read, mem_address);
        end
        for (int k = 0; k < 4; k++) begin
            mem_resp  = 1'b1;
            mem_rdata = line[64*k +: 64];
            @(negedge clk);
            if (k == 1) begin
                mem_resp = 1'b0;
                @(negedge clk);
            end
        end
        mem_resp = 1'b0;
        cyc = 0;
        while (pmem_resp !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 0) begin
            errors++;
            $display("FAIL fresh_resp_timing: resp %0d cycles late want 0", cyc);
        end
        exp = (rd_q.size() > 0) ? rd_q.pop_front() : 256'h0;
        checks++;
        if (pmem_rdata !== exp) begin
            errors++;
            $display("FAIL fresh_line: got %h want %h", pmem_rdata, exp);
        end
        last_line = exp;
        pmem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_resp !== 1'b0 || pmem_rdata !== last_line) begin
            errors++;
            $display("FAIL fresh_hold: resp=%b rdata=%h want 0 %h", pmem_resp, pmem_rdata, last_line);
        end
    endtask

    initial begin
        last_line = '0;
        test_reset();
        test_read_back_to_back();
        test_write_with_gaps();
        test_simultaneous();
        test_stray_resp();
        test_reset_mid_read();
        checks++;
        if (rd_q.size() != 0 || wd_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: rd_q=%0d wd_q=%0d left want 0 0", rd_q.size(), wd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_l2_line_adaptor
`default_nettype wire

// File: doc/l2_line_adaptor.md
# l2_line_adaptor

Responder on the L2 cache's physical-memory side. It accepts a 256-bit line read or write request from the L2 cache, translates it into a four-beat 64-bit burst transaction toward main memory, and returns a single-cycle completion to the L2. It sits between the L2 cache's pmem port and the DRAM model or controller.

## Interface
Parameters:
- s_line, 256, line width in bits
- s_burst, 64, burst beat width in bits
- num_beats, s_line/s_burst (4), beats per line

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pmem_read  in  1  L2 line-read request, held until pmem_resp
- pmem_write  in  1  L2 line-write request, held until pmem_resp
- pmem_address  in  32  L2 line address
- pmem_wdata  in  256  line to write
- pmem_rdata  out  256  assembled read line
- pmem_resp  out  1  one-cycle completion to L2
- mem_read  out  1  burst read request to memory
- mem_write  out  1  burst write request to memory
- mem_address  out  32  latched line address, low 5 bits zero
- mem_wdata  out  64  current write beat
- mem_rdata  in  64  current read beat
- mem_resp  in  1  memory beat strobe, one per accepted beat

## Operation
- States: IDLE, READ, READ_DONE, WRITE, WRITE_DONE. A 2-bit beat counter tracks progress.
- IDLE:
  - On pmem_write, latch {pmem_address[31:5],5'b0} and pmem_wdata, clear the counter, and go to WRITE.
  - Otherwise, on pmem_read, latch the address, clear the counter, and go to READ.
  - If both are high, write wins. The read is not served until it is presented again from IDLE.
  - mem_resp in IDLE is ignored.
- READ:
  - mem_read=1.
  - On each cycle with mem_resp=1, store mem_rdata into beat slot [64k+63:64k], where k is the counter value, then increment the counter.
  - After beat 3 is stored, go to READ_DONE.
- READ_DONE:
  - pmem_resp=1 for exactly one cycle; pmem_rdata holds the full line.
  - Then go to IDLE.
- WRITE:
  - mem_write=1; mem_wdata = latched line[64k+63:64k].
  - On each mem_resp=1, increment the counter. After beat 3, go to WRITE_DONE.
- WRITE_DONE:
  - pmem_resp=1 for one cycle, then go to IDLE.
- Beat order is always beat 0 (bits 63:0) first.
- mem_resp may be non-consecutive. Cycles without mem_resp hold the state, the counter, and the outputs.
- pmem_address and pmem_wdata are sampled only in IDLE. Changes during a transaction have no effect.

## Timing
- Reset values: pmem_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, pmem_rdata=0. State=IDLE, counter=0, line buffers=0.
- Request seen in IDLE at edge N: mem_read or mem_write is high from cycle N+1.
- Fourth mem_resp at edge M: mem_read/mem_write deassert in cycle M+1, and pmem_resp=1 in cycle M+1 only.
- Minimum read or write latency is 6 cycles from request to pmem_resp: 1 request cycle, 4 beat cycles, 1 done cycle.
- pmem_rdata is stable from READ_DONE until the next read completes. Write transactions do not disturb it.
- The adaptor samples IDLE at the edge after pmem_resp. The L2 must have dropped its request by then, and the adaptor does not re-check.
- Reset asserted mid-transaction: immediate return to the reset values. Any partial line is discarded and no pmem_resp is issued.
- Counter wrap from 3 to 0 coincides with leaving READ or WRITE. A mem_resp in READ_DONE or WRITE_DONE is ignored.

## Structure
- Shared package l2_pkg holds:
  - the state enum (IDLE, READ, READ_DONE, WRITE, WRITE_DONE)
  - the beat-counter width
  - the line, burst, and offset constants (5 offset bits)
- No sub-module is warranted. The beat counter, line buffer, and beat mux are inline in one always_ff / always_comb pair.

## Test plan
- Read, back-to-back beats:
  - Stimulus: pmem_read with address 0x0000_1234; memory returns mem_rdata 0x11…11, 0x22…22, 0x33…33, 0x44…44 on 4 consecutive mem_resp cycles.
  - Required: mem_address=0x0000_1220; pmem_rdata={0x44…,0x33…,0x22…,0x11…}; pmem_resp high exactly one cycle, 6 cycles after the request.
- Write with gaps:
  - Stimulus: pmem_write with pmem_wdata = 256'h(bytes 0x00..0x1F) and address 0x8000_0040; mem_resp arrives with 2 idle cycles between beats.
  - Required: mem_wdata steps 0x0706050403020100, 0x0F0E…08, 0x1716…10, 0x1F1E…18, holding during the gaps; one pmem_resp.
- Simultaneous pmem_read=pmem_write=1:
  - Required: the write is performed (mem_write=1, mem_read=0).
- Stray mem_resp:
  - Stimulus: mem_resp pulsed while in IDLE.
  - Required: no state change; outputs unchanged.
- Reset mid-operation:
  - Stimulus: rst asserted after 2 read beats, then a fresh read.
  - Required: outputs return to 0 immediately, no pmem_resp for the aborted read, and the fresh read assembles all 4 new beats correctly.
